// File: rtl/dsp_mac_pipe.sv
// Four-stage pipelined pre-add / multiply / post-add MAC slice with a per-sample
// opcode and valid flag travelling alongside the data; P doubles as the accumulator.
module dsp_mac_pipe #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [3:0]         opmode,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [C_WIDTH-1:0] C,
    input  logic [B_WIDTH-1:0] D,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] P,
    output logic               ovf
);

    localparam int M_WIDTH = A_WIDTH + B_WIDTH;

    // Stage 1
    logic signed [A_WIDTH-1:0] a1_q, a1_d;
    logic signed [B_WIDTH-1:0] b1_q, b1_d, d1_q, d1_d;
    logic signed [C_WIDTH-1:0] c1_q, c1_d;
    logic [3:0]                op1_q, op1_d;
    logic                      v1_q, v1_d;
    // Stage 2 (opcode narrowed to the post-adder bits {zsel, post-sub})
    logic signed [B_WIDTH-1:0] pre2_q, pre2_d;
    logic signed [A_WIDTH-1:0] a2_q, a2_d;
    logic signed [C_WIDTH-1:0] c2_q, c2_d;
    logic [1:0]                op2_q, op2_d;
    logic                      v2_q, v2_d;
    // Stage 3
    logic signed [M_WIDTH-1:0] m3_q, m3_d;
    logic signed [C_WIDTH-1:0] c3_q, c3_d;
    logic [1:0]                op3_q, op3_d;
    logic                      v3_q, v3_d;
    // Stage 4
    logic signed [P_WIDTH-1:0] p_q, p_d;
    logic                      ovf_q, ovf_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [M_WIDTH-1:0] a_ext, pre_ext;
    logic signed [P_WIDTH-1:0] z_val, m_ext, post_sum;
    logic                      post_ovf;

    always_comb begin
        a_ext   = M_WIDTH'(a2_q);
        pre_ext = M_WIDTH'(pre2_q);
        z_val   = op3_q[1] ? p_q : P_WIDTH'(c3_q);
        m_ext   = P_WIDTH'(m3_q);
        if (op3_q[0]) begin
            post_sum = z_val - m_ext;
            post_ovf = (z_val[P_WIDTH-1] != m_ext[P_WIDTH-1]) &&
                       (post_sum[P_WIDTH-1] != z_val[P_WIDTH-1]);
        end else begin
            post_sum = z_val + m_ext;
            post_ovf = (z_val[P_WIDTH-1] == m_ext[P_WIDTH-1]) &&
                       (post_sum[P_WIDTH-1] != z_val[P_WIDTH-1]);
        end
    end

    always_comb begin
        a1_d        = a1_q;
        b1_d        = b1_q;
        c1_d        = c1_q;
        d1_d        = d1_q;
        op1_d       = op1_q;
        v1_d        = v1_q;
        pre2_d      = pre2_q;
        a2_d        = a2_q;
        c2_d        = c2_q;
        op2_d       = op2_q;
        v2_d        = v2_q;
        m3_d        = m3_q;
        c3_d        = c3_q;
        op3_d       = op3_q;
        v3_d        = v3_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            a1_d  = A;
            b1_d  = B;
            c1_d  = C;
            d1_d  = D;
            op1_d = opmode;
            v1_d  = in_valid;

            if (op1_q[1])
                pre2_d = b1_q;
            else if (op1_q[0])
                pre2_d = d1_q - b1_q;
            else
                pre2_d = d1_q + b1_q;
            a2_d  = a1_q;
            c2_d  = c1_q;
            op2_d = op1_q[3:2];
            v2_d  = v1_q;

            m3_d  = a_ext * pre_ext;
            c3_d  = c2_q;
            op3_d = op2_q;
            v3_d  = v2_q;

            // Bubbles must not disturb the accumulator or the overflow flag.
            out_valid_d = v3_q;
            if (v3_q) begin
                p_d   = post_sum;
                ovf_d = post_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a1_q        <= '0;
            b1_q        <= '0;
            c1_q        <= '0;
            d1_q        <= '0;
            op1_q       <= '0;
            v1_q        <= 1'b0;
            pre2_q      <= '0;
            a2_q        <= '0;
            c2_q        <= '0;
            op2_q       <= '0;
            v2_q        <= 1'b0;
            m3_q        <= '0;
            c3_q        <= '0;
            op3_q       <= '0;
            v3_q        <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            c1_q        <= c1_d;
            d1_q        <= d1_d;
            op1_q       <= op1_d;
            v1_q        <= v1_d;
            pre2_q      <= pre2_d;
            a2_q        <= a2_d;
            c2_q        <= c2_d;
            op2_q       <= op2_d;
            v2_q        <= v2_d;
            m3_q        <= m3_d;
            c3_q        <= c3_d;
            op3_q       <= op3_d;
            v3_q        <= v3_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a driver pushes reference-model results,
// a monitor pops them as out_valid appears and also checks reset, stall and bubble behaviour.
module tb_dsp_mac_pipe;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int CW = 48;
    localparam int PW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b1;
    logic          in_valid = 1'b0;
    logic [3:0]    opmode = '0;
    logic [AW-1:0] a_in = '0;
    logic [BW-1:0] b_in = '0;
    logic [CW-1:0] c_in = '0;
    logic [BW-1:0] d_in = '0;
    logic          out_valid;
    logic [PW-1:0] p_out;
    logic          ovf;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .P_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a_in), .B(b_in), .C(c_in), .D(d_in),
        .out_valid(out_valid), .P(p_out), .ovf(ovf)
    );

    typedef struct {
        logic [PW-1:0] p;
        logic          ovf;
        int            cap;
    } exp_t;

    exp_t   scb[$];
    int     npass = 0;
    int     ntotal = 0;
    longint model_p = 0;
    int     en_drive = 0;
    int     en_mon = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        ntotal++;
        if (act === req) npass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endfunction

    // Reference: exact integer arithmetic, then wrap to the hardware widths.
    function automatic void model(input logic [3:0] op, input logic [AW-1:0] a,
                                  input logic [BW-1:0] b, input logic [CW-1:0] c,
                                  input logic [BW-1:0] d,
                                  output logic [PW-1:0] p, output logic o);
        longint sa, sbv, sc, sd, pre, m, z, r, rw;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sc  = longint'($signed(c));
        sd  = longint'($signed(d));
        if (op[1]) pre = sbv;
        else if (op[0]) pre = sd - sbv;
        else pre = sd + sbv;
        pre = (pre <<< (64 - BW)) >>> (64 - BW);
        m = sa * pre;
        z = op[3] ? model_p : sc;
        r = op[2] ? z - m : z + m;
        rw = (r <<< (64 - PW)) >>> (64 - PW);
        o = (rw != r);
        p = PW'(rw);
        model_p = rw;
    endfunction

    task automatic cyc(input logic ce_v, input logic rst_v, input logic vld,
                       input logic [3:0] op, input logic [AW-1:0] a, input logic [BW-1:0] b,
                       input logic [CW-1:0] c, input logic [BW-1:0] d,
                       input logic has_exp = 1'b0, input logic [PW-1:0] ep = '0,
                       input logic eo = 1'b0);
        exp_t e;
        logic [PW-1:0] mp;
        logic mo;
        @(posedge clk);
        #3;
        ce = ce_v; rst_n = rst_v; in_valid = vld; opmode = op;
        a_in = a; b_in = b; c_in = c; d_in = d;
        if (!rst_v) begin
            scb.delete();
            model_p = 0;
        end else if (ce_v) begin
            en_drive++;
            if (vld) begin
                model(op, a, b, c, d, mp, mo);
                e.p   = has_exp ? ep : mp;
                e.ovf = has_exp ? eo : mo;
                e.cap = en_drive;
                scb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 1'b0, 4'h0, '0, '0, '0, '0);
    endtask

    task automatic rnd(input logic ce_v, input logic rst_v, input logic vld);
        logic [AW-1:0] a;
        logic [BW-1:0] b, d;
        logic [CW-1:0] c;
        logic [3:0] op;
        a = AW'($urandom);
        b = BW'($urandom);
        d = BW'($urandom);
        c = CW'({$urandom, $urandom});
        op = 4'($urandom);
        cyc(ce_v, rst_v, vld, op, a, b, c, d);
    endtask

    logic          mon_en, mon_rs;
    logic [PW-1:0] prev_p = '0;
    logic          prev_ovf = 1'b0;
    logic          prev_ov = 1'b0;
    exp_t          me;

    always @(posedge clk) begin
        mon_en = ce && rst_n;
        mon_rs = !rst_n;
        #1;
        if (mon_rs) begin
            check("reset_p", 64'(p_out), 64'(0));
            check("reset_ovf", 64'(ovf), 64'(0));
            check("reset_out_valid", 64'(out_valid), 64'(0));
        end else if (!mon_en) begin
            check("stall_p", 64'(p_out), 64'(prev_p));
            check("stall_ovf", 64'(ovf), 64'(prev_ovf));
            check("stall_out_valid", 64'(out_valid), 64'(prev_ov));
        end else begin
            en_mon++;
            if (out_valid) begin
                if (scb.size() == 0) begin
                    check("unexpected_out_valid", 64'(1), 64'(0));
                end else begin
                    me = scb.pop_front();
                    check("result_p", 64'(p_out), 64'(me.p));
                    check("result_ovf", 64'(ovf), 64'(me.ovf));
                    check("latency", 64'(en_mon), 64'(me.cap + 3));
                end
            end else begin
                check("bubble_hold_p", 64'(p_out), 64'(prev_p));
            end
        end
        prev_p = p_out;
        prev_ovf = ovf;
        prev_ov = out_valid;
    end

    initial begin
        // Reset held with live random inputs.
        for (int i = 0; i < 3; i++) rnd(1'b1, 1'b0, 1'b1);

        // Basic add and pre-subtract.
        cyc(1, 1, 1, 4'b0000, 18'd1, 18'd2, 48'h3, 18'd4, 1'b1, 48'h9, 1'b0);
        cyc(1, 1, 1, 4'b0001, 18'd2, 18'd3, 48'h10, 18'd1, 1'b1, 48'hC, 1'b0);
        for (int i = 0; i < 4; i++) idle();

        // Accumulate with a bubble mid-stream.
        cyc(1, 1, 1, 4'b0010, 18'd2, 18'd3, 48'h10, 18'd0, 1'b1, 48'h16, 1'b0);
        cyc(1, 1, 1, 4'b1010, 18'd1, 18'd5, 48'h0, 18'd0, 1'b1, 48'h1B, 1'b0);
        idle();
        cyc(1, 1, 1, 4'b1010, 18'd1, 18'd5, 48'h0, 18'd0, 1'b1, 48'h20, 1'b0);
        cyc(1, 1, 1, 4'b1010, 18'd1, 18'd5, 48'h0, 18'd0, 1'b1, 48'h25, 1'b0);
        for (int i = 0; i < 4; i++) idle();

        // Overflow into the sign bit, then cleared by a benign sample.
        cyc(1, 1, 1, 4'b0010, 18'd1, 18'd1, 48'h7FFF_FFFF_FFFF, 18'd0, 1'b1, 48'h8000_0000_0000, 1'b1);
        cyc(1, 1, 1, 4'b0010, 18'd1, 18'd1, 48'h0, 18'd0, 1'b1, 48'h1, 1'b0);
        for (int i = 0; i < 4; i++) idle();

        // Six-sample stream with a three-cycle ce stall in the middle.
        for (int i = 0; i < 3; i++) rnd(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) rnd(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) idle();

        // Reset while three samples are in flight.
        for (int i = 0; i < 3; i++) rnd(1'b1, 1'b1, 1'b1);
        cyc(1, 0, 1, 4'b0000, 18'd7, 18'd7, 48'h7, 18'd7);
        for (int i = 0; i < 5; i++) idle();
        cyc(1, 1, 1, 4'b1010, 18'd1, 18'd5, 48'h0, 18'd0, 1'b1, 48'h5, 1'b0);
        for (int i = 0; i < 4; i++) idle();

        // Randomised stream with stalls, bubbles and rare resets.
        for (int i = 0; i < 400; i++)
            rnd($urandom_range(0, 7) != 0, $urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);

        for (int i = 0; i < 20 && scb.size() != 0; i++) idle();
        check("drain_scoreboard_empty", 64'(scb.size()), 64'(0));
        idle();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
